// File: rtl/seg7_pair_scheduler.sv
// rtl/seg7_pair_scheduler.sv - two-digit BCD counter sharing one 7-segment decoder
//
// Keeps a 00-99 BCD count driven by single-cycle inc/dec/clear pulses and
// refreshes two active-low digit registers by time-multiplexing an external
// binary-to-7-segment decoder (input-to-output latency DEC_LATENCY cycles).
//
// Ports:
//   i_Clk         system clock, rising edge
//   i_Reset       synchronous active-high reset
//   i_Inc/i_Dec   count +1 / -1 pulses (both together: no change)
//   i_Clear       count := 00 pulse, wins over inc/dec
//   o_Decode_Num  digit value presented to the shared decoder
//   i_Seg         decoder result, active-high, bit6=A .. bit0=G
//   o_Segment1    tens digit pins, active-low
//   o_Segment2    ones digit pins, active-low
//   o_Busy        high while a decode pass is in progress
module seg7_pair_scheduler #(
   parameter int DEC_LATENCY   = 1,
   parameter bit BLANK_LEADING = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Inc,
   input  logic       i_Dec,
   input  logic       i_Clear,
   output logic [3:0] o_Decode_Num,
   input  logic [6:0] i_Seg,
   output logic [6:0] o_Segment1,
   output logic [6:0] o_Segment2,
   output logic       o_Busy
);

   typedef enum logic [1:0] {IDLE, WAIT_TENS, WAIT_ONES} state_t;

   localparam logic [2:0] LAT = 3'(DEC_LATENCY);

   state_t     state;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [3:0] ones_snap;
   logic       dirty;
   logic [2:0] wait_cnt;

   logic do_inc;
   logic do_dec;
   logic event_hit;

   assign do_inc    = i_Inc & ~i_Dec & ~i_Clear;
   assign do_dec    = i_Dec & ~i_Inc & ~i_Clear;
   assign event_hit = i_Clear | (i_Inc ^ i_Dec);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state        <= IDLE;
         tens         <= 4'd0;
         ones         <= 4'd0;
         ones_snap    <= 4'd0;
         dirty        <= 1'b1;
         wait_cnt     <= 3'd0;
         o_Decode_Num <= 4'd0;
         o_Segment1   <= 7'h7F;
         o_Segment2   <= 7'h7F;
         o_Busy       <= 1'b0;
      end else begin
         // Count path runs independently of the refresh FSM.
         if (i_Clear) begin
            tens <= 4'd0;
            ones <= 4'd0;
         end else if (do_inc) begin
            if (ones == 4'd9) begin
               ones <= 4'd0;
               tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
               ones <= ones + 4'd1;
            end
         end else if (do_dec) begin
            if (ones == 4'd0) begin
               ones <= 4'd9;
               tens <= (tens == 4'd0) ? 4'd9 : tens - 4'd1;
            end else begin
               ones <= ones - 4'd1;
            end
         end

         // A pass starting this cycle consumes dirty, but an event arriving
         // on the same edge must still leave a pass pending.
         if (event_hit)
            dirty <= 1'b1;
         else if (state == IDLE)
            dirty <= 1'b0;

         case (state)
            IDLE: begin
               if (dirty) begin
                  // Tens and ones both come from this edge's count value.
                  o_Decode_Num <= tens;
                  ones_snap    <= ones;
                  wait_cnt     <= LAT;
                  o_Busy       <= 1'b1;
                  state        <= WAIT_TENS;
               end
            end
            WAIT_TENS: begin
               if (wait_cnt == 3'd0) begin
                  // o_Decode_Num still holds the issued tens digit here.
                  if (BLANK_LEADING && (o_Decode_Num == 4'd0))
                     o_Segment1 <= 7'h7F;
                  else
                     o_Segment1 <= ~i_Seg;
                  o_Decode_Num <= ones_snap;
                  wait_cnt     <= LAT;
                  state        <= WAIT_ONES;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            WAIT_ONES: begin
               if (wait_cnt == 3'd0) begin
                  o_Segment2 <= ~i_Seg;
                  o_Busy     <= 1'b0;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            default: begin
               o_Busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_pair_scheduler.sv
// tb/tb_seg7_pair_scheduler.sv - scoreboard bench for seg7_pair_scheduler
module tb_seg7_pair_scheduler;

   localparam int LA = 1;
   localparam int LB = 3;

   typedef struct {
      logic [3:0] tens;
      logic [3:0] ones;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, inc_a = 1'b0, dec_a = 1'b0, clr_a = 1'b0;
   logic       rst_b = 1'b1, inc_b = 1'b0, dec_b = 1'b0, clr_b = 1'b0;
   logic [3:0] num_a, num_b;
   logic [6:0] seg_in_a, seg_in_b;
   logic [6:0] seg1_a, seg2_a, seg1_b, seg2_b;
   logic       busy_a, busy_b;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   int   passes_a = 0, passes_b = 0;
   int   len_a = 0, len_b = 0;
   logic busy_a_d = 1'b0, busy_b_d = 1'b0;
   logic mon_a = 1'b0, mon_b = 1'b0;
   logic abort_b = 1'b0;

   function automatic logic [6:0] lut(input logic [3:0] d);
      case (d)
         4'd0: lut = 7'h7E;  4'd1: lut = 7'h30;  4'd2: lut = 7'h6D;
         4'd3: lut = 7'h79;  4'd4: lut = 7'h33;  4'd5: lut = 7'h5B;
         4'd6: lut = 7'h5F;  4'd7: lut = 7'h70;  4'd8: lut = 7'h7F;
         4'd9: lut = 7'h7B;  default: lut = 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] pin(input logic [3:0] d, input bit blank);
      logic [6:0] v;
      v = lut(d);
      pin = (blank && d == 4'd0) ? 7'h7F : ~v;
   endfunction

   function automatic exp_t mk(input int count);
      exp_t e;
      e.tens = 4'(count / 10);
      e.ones = 4'(count % 10);
      return e;
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Decoder models: one register stage per cycle of latency.
   logic [6:0] pipe_a [LA];
   logic [6:0] pipe_b [LB];
   always @(posedge clk) begin
      pipe_a[0] <= lut(num_a);
      for (int i = 1; i < LA; i++) pipe_a[i] <= pipe_a[i-1];
      pipe_b[0] <= lut(num_b);
      for (int j = 1; j < LB; j++) pipe_b[j] <= pipe_b[j-1];
   end
   assign seg_in_a = pipe_a[LA-1];
   assign seg_in_b = pipe_b[LB-1];

   seg7_pair_scheduler #(.DEC_LATENCY(LA), .BLANK_LEADING(1'b0)) dut_a (
      .i_Clk(clk), .i_Reset(rst_a), .i_Inc(inc_a), .i_Dec(dec_a), .i_Clear(clr_a),
      .o_Decode_Num(num_a), .i_Seg(seg_in_a),
      .o_Segment1(seg1_a), .o_Segment2(seg2_a), .o_Busy(busy_a));

   seg7_pair_scheduler #(.DEC_LATENCY(LB), .BLANK_LEADING(1'b1)) dut_b (
      .i_Clk(clk), .i_Reset(rst_b), .i_Inc(inc_b), .i_Dec(dec_b), .i_Clear(clr_b),
      .o_Decode_Num(num_b), .i_Seg(seg_in_b),
      .o_Segment1(seg1_b), .o_Segment2(seg2_b), .o_Busy(busy_b));

   // Pass monitors: compare issued tens at pass start, pins and length at pass end.
   always @(negedge clk) begin
      exp_t e;
      if (mon_a) begin
         if (busy_a && !busy_a_d) begin
            len_a = 0;
            if (q_a.size() > 0) check_eq("a_issue_tens", num_a, q_a[0].tens);
         end
         if (busy_a) len_a++;
         if (!busy_a && busy_a_d) begin
            passes_a++;
            if (q_a.size() == 0) check_eq("a_unexpected_pass", 1, 0);
            else begin
               e = q_a.pop_front();
               check_eq("a_seg1", seg1_a, pin(e.tens, 1'b0));
               check_eq("a_seg2", seg2_a, pin(e.ones, 1'b0));
               check_eq("a_pass_len", len_a, 2*LA+2);
            end
         end
      end
      busy_a_d = busy_a;
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_b) begin
         if (busy_b && !busy_b_d) begin
            len_b = 0;
            if (q_b.size() > 0 && !abort_b) check_eq("b_issue_tens", num_b, q_b[0].tens);
         end
         if (busy_b) len_b++;
         if (!busy_b && busy_b_d) begin
            if (abort_b) abort_b = 1'b0;
            else begin
               passes_b++;
               if (q_b.size() == 0) check_eq("b_unexpected_pass", 1, 0);
               else begin
                  e = q_b.pop_front();
                  check_eq("b_seg1", seg1_b, pin(e.tens, 1'b1));
                  check_eq("b_seg2", seg2_b, pin(e.ones, 1'b0));
                  check_eq("b_pass_len", len_b, 2*LB+2);
               end
            end
         end
      end
      busy_b_d = busy_b;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_a(input logic inc, input logic dec, input logic clr);
      inc_a = inc; dec_a = dec; clr_a = clr;
      step(1);
      inc_a = 1'b0; dec_a = 1'b0; clr_a = 1'b0;
   endtask

   task automatic drive_b(input logic inc, input logic dec, input logic clr);
      inc_b = inc; dec_b = dec; clr_b = clr;
      step(1);
      inc_b = 1'b0; dec_b = 1'b0; clr_b = 1'b0;
   endtask

   int ma = 0;
   int mb = 0;
   int p0;
   int t;

   initial begin
      // ---------------- instance A: L=1, no blanking ----------------
      step(3);
      check_eq("a_rst_seg1", seg1_a, 7'h7F);
      check_eq("a_rst_seg2", seg2_a, 7'h7F);
      check_eq("a_rst_busy", busy_a, 0);
      check_eq("a_rst_num", num_a, 0);
      mon_a = 1'b1;
      q_a.push_back(mk(0));
      rst_a = 1'b0;
      step(10);
      check_eq("a_boot_seg2", seg2_a, 7'h01);

      for (int i = 0; i < 12; i++) begin
         drive_a(1'b1, 1'b0, 1'b0);
         ma = (ma + 1) % 100;
         q_a.push_back(mk(ma));
         step(9);
      end
      check_eq("a_12_seg1", seg1_a, 7'h4F);
      check_eq("a_12_seg2", seg2_a, 7'h12);

      drive_a(1'b0, 1'b0, 1'b1); ma = 0;  q_a.push_back(mk(ma)); step(9);
      drive_a(1'b0, 1'b1, 1'b0); ma = 99; q_a.push_back(mk(ma)); step(9);
      check_eq("a_99_seg1", seg1_a, 7'h04);
      check_eq("a_99_seg2", seg2_a, 7'h04);
      drive_a(1'b1, 1'b0, 1'b0); ma = 0;  q_a.push_back(mk(ma)); step(9);
      check_eq("a_wrap_seg2", seg2_a, 7'h01);

      // Three incs while a pass is in flight coalesce into one follow-up pass.
      p0 = passes_a;
      drive_a(1'b0, 1'b0, 1'b1); ma = 0; q_a.push_back(mk(ma));
      step(1);
      for (int i = 0; i < 3; i++) drive_a(1'b1, 1'b0, 1'b0);
      ma = 3; q_a.push_back(mk(ma));
      step(15);
      check_eq("a_coalesce_passes", passes_a - p0, 2);

      for (int i = 0; i < 54; i++) begin
         drive_a(1'b1, 1'b0, 1'b0);
         ma = (ma + 1) % 100;
         q_a.push_back(mk(ma));
         step(9);
      end
      check_eq("a_57_seg1", seg1_a, pin(4'd5, 1'b0));
      drive_a(1'b1, 1'b0, 1'b1); ma = 0; q_a.push_back(mk(ma)); step(9);
      check_eq("a_clr_inc_seg2", seg2_a, 7'h01);
      p0 = passes_a;
      drive_a(1'b1, 1'b1, 1'b0);
      step(12);
      check_eq("a_incdec_no_pass", passes_a - p0, 0);
      check_eq("a_queue_empty", q_a.size(), 0);

      // ---------------- instance B: L=3, leading blank ----------------
      check_eq("b_rst_seg2", seg2_b, 7'h7F);
      check_eq("b_rst_busy", busy_b, 0);
      mon_b = 1'b1;
      q_b.push_back(mk(0));
      rst_b = 1'b0;
      step(15);
      for (int i = 0; i < 7; i++) begin
         drive_b(1'b1, 1'b0, 1'b0);
         mb = mb + 1;
         q_b.push_back(mk(mb));
         step(14);
      end
      check_eq("b_07_seg1", seg1_b, 7'h7F);
      check_eq("b_07_seg2", seg2_b, 7'h0F);

      // Reset during WAIT_ONES abandons the pass.
      abort_b = 1'b1;
      drive_b(1'b1, 1'b0, 1'b0);
      t = 0;
      while (!busy_b && t < 5) begin
         step(1);
         t++;
      end
      check_eq("b_busy_rise", busy_b, 1);
      step(LB + 1);
      check_eq("b_mid_pass_busy", busy_b, 1);
      rst_b = 1'b1;
      step(1);
      check_eq("b_abort_seg1", seg1_b, 7'h7F);
      check_eq("b_abort_seg2", seg2_b, 7'h7F);
      check_eq("b_abort_busy", busy_b, 0);
      check_eq("b_abort_num", num_b, 0);
      mb = 0;
      q_b.push_back(mk(0));
      rst_b = 1'b0;
      step(15);
      check_eq("b_queue_empty", q_b.size(), 0);
      check_eq("b_pass_count", passes_b, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
